// File: rtl/sdram_vga_rd_buf.sv
// Read-side prefetch buffer: issues fixed-length SDRAM read bursts over a linear
// frame region and serves the returned pixels to VGA through a FWFT FIFO.
module sdram_vga_rd_buf #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 307200
) (
  input  logic                      Sys_clk,
  input  logic                      Rst_n,
  input  logic                      sdram_init_done,
  input  logic                      frame_start,
  output logic                      rd_req,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      rd_ack,
  input  logic                      rd_data_valid,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      SDRAM_FIFO_RD_EN,
  output logic [DATA_WIDTH-1:0]     SDRAM_FIFO_RD_DATA,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      underflow,
  output logic                      overflow
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(BURST_LEN);
  localparam logic [CntW-1:0]       FullCnt  = CntW'(DEPTH);
  localparam logic [CntW-1:0]       BurstCnt = CntW'(BURST_LEN);
  localparam logic [BeatW-1:0]      LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                  state_q, state_d;
  logic                    rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d, next_addr;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic                    discard_q, discard_d;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         cnt_q;
  logic                    underflow_q, overflow_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic fifo_empty, fifo_full, room_ok, push_req, push, pop;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FullCnt);
  // Space for a whole burst is reserved before requesting, so a compliant
  // controller never overflows the FIFO.
  assign room_ok    = (FullCnt - cnt_q) >= BurstCnt;
  assign push_req   = (state_q == StWait) && rd_data_valid && !discard_q && !frame_start;
  assign push       = push_req && !fifo_full;
  assign pop        = SDRAM_FIFO_RD_EN && !fifo_empty && !frame_start;
  assign next_addr  = (rd_addr_q == LastAddr) ? BaseAddr : rd_addr_q + AddrStep;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    beat_d    = beat_q;
    discard_d = discard_q;
    if (frame_start) rd_addr_d = BaseAddr;
    unique case (state_q)
      StIdle: begin
        if (sdram_init_done && !frame_start && room_ok) state_d = StReq;
      end
      StReq: begin
        if (rd_ack) begin
          state_d   = StWait;
          beat_d    = '0;
          discard_d = frame_start;
        end else if (frame_start) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (frame_start) discard_d = 1'b1;
        if (rd_data_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            state_d   = StIdle;
            discard_d = 1'b0;
            // A flushed burst leaves the address parked at the frame base.
            if (!discard_q && !frame_start) rd_addr_d = next_addr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    rd_req_d = (state_d == StReq);
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      rd_req_q  <= 1'b0;
      rd_addr_q <= BaseAddr;
      beat_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      beat_q    <= beat_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (frame_start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (SDRAM_FIFO_RD_EN && fifo_empty) underflow_q <= 1'b1;
      if (push_req && fifo_full)          overflow_q  <= 1'b1;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (push) mem[wr_ptr_q] <= rd_data;
  end

  assign rd_req             = rd_req_q;
  assign rd_addr            = rd_addr_q;
  assign SDRAM_FIFO_RD_DATA = fifo_empty ? '0 : mem[rd_ptr_q];
  assign fifo_cnt           = cnt_q;
  assign underflow          = underflow_q;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_sdram_vga_rd_buf.sv
// Directed bench for sdram_vga_rd_buf: a small SDRAM controller model answers
// requests while the main thread pops, flushes and resets.
module tb_sdram_vga_rd_buf;

  localparam int unsigned DataW  = 8;
  localparam int unsigned Depth  = 64;
  localparam int unsigned Burst  = 16;
  localparam int unsigned AddrW  = 24;
  localparam int unsigned Base   = 'h100;
  localparam int unsigned Frame  = 64;
  localparam int          Budget = 300;

  logic              Sys_clk = 1'b0;
  logic              Rst_n;
  logic              sdram_init_done;
  logic              frame_start;
  logic              rd_req;
  logic [AddrW-1:0]  rd_addr;
  logic              rd_ack;
  logic              rd_data_valid;
  logic [DataW-1:0]  rd_data;
  logic              SDRAM_FIFO_RD_EN;
  logic [DataW-1:0]  SDRAM_FIFO_RD_DATA;
  logic [6:0]        fifo_cnt;
  logic              underflow;
  logic              overflow;

  sdram_vga_rd_buf #(
    .DATA_WIDTH (DataW),
    .DEPTH      (Depth),
    .BURST_LEN  (Burst),
    .ADDR_WIDTH (AddrW),
    .BASE_ADDR  (Base),
    .FRAME_WORDS(Frame)
  ) dut (
    .Sys_clk           (Sys_clk),
    .Rst_n             (Rst_n),
    .sdram_init_done   (sdram_init_done),
    .frame_start       (frame_start),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_ack            (rd_ack),
    .rd_data_valid     (rd_data_valid),
    .rd_data           (rd_data),
    .SDRAM_FIFO_RD_EN  (SDRAM_FIFO_RD_EN),
    .SDRAM_FIFO_RD_DATA(SDRAM_FIFO_RD_DATA),
    .fifo_cnt          (fifo_cnt),
    .underflow         (underflow),
    .overflow          (overflow)
  );

  always #5 Sys_clk = ~Sys_clk;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [AddrW-1:0] addr_log[$];
  logic [DataW-1:0] data_ctr = '0;
  int               ctrl_beat = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Controller model: acks two cycles after a request, then streams 16 beats
  // from a running counter. It acts at +1 after each edge, the main thread at +2.
  initial begin
    rd_ack        = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    forever begin
      @(posedge Sys_clk); #1;
      if (rd_req) begin
        addr_log.push_back(rd_addr);
        repeat (2) begin @(posedge Sys_clk); #1; end
        rd_ack = 1'b1;
        @(posedge Sys_clk); #1;
        rd_ack = 1'b0;
        for (int b = 0; b < int'(Burst); b++) begin
          rd_data_valid = 1'b1;
          rd_data       = data_ctr;
          ctrl_beat     = b;
          @(posedge Sys_clk); #1;
          data_ctr++;
        end
        rd_data_valid = 1'b0;
        ctrl_beat     = -1;
      end
    end
  end

  task automatic tick();
    @(posedge Sys_clk); #2;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int size);
    int n = 0;
    while (addr_log.size() < size && n < Budget) begin tick(); n++; end
    check(tag, 32'(n < Budget), 32'd1);
  endtask

  task automatic wait_beat(input string tag, input int beat);
    int n = 0;
    while (!(rd_data_valid && ctrl_beat == beat) && n < Budget) begin tick(); n++; end
    check(tag, 32'(n < Budget), 32'd1);
  endtask

  function automatic logic [31:0] log_at(input int idx);
    return (idx < addr_log.size()) ? 32'(addr_log[idx]) : 32'hdead_beef;
  endfunction

  initial begin
    logic [DataW-1:0] exp_pix;
    int n, n0;
    Rst_n            = 1'b0;
    sdram_init_done  = 1'b1;
    frame_start      = 1'b0;
    SDRAM_FIFO_RD_EN = 1'b0;
    repeat (3) tick();

    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'h100);
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_rd_data", 32'(SDRAM_FIFO_RD_DATA), 32'd0);
    check("rst_flags", 32'({underflow, overflow}), 32'd0);
    Rst_n = 1'b1;

    // Fill: four bursts, then the reservation blocks a fifth.
    n = 0;
    while (fifo_cnt != 7'd64 && n < Budget) begin tick(); n++; end
    check("t1_fill_done", 32'(n < Budget), 32'd1);
    for (int i = 0; i < 4; i++) check("t1_burst_addr", log_at(i), 32'h100 + 32'(i) * 32'h10);
    repeat (40) tick();
    check("t1_no_fifth_req", 32'(addr_log.size()), 32'd4);
    check("t1_rd_req_low", 32'(rd_req), 32'd0);
    check("t1_addr_wrapped", 32'(rd_addr), 32'h100);

    // Drain at a 4:1 on/off ratio; refill must keep the data ordered.
    exp_pix = '0;
    for (int c = 0; c < 250; c++) begin
      SDRAM_FIFO_RD_EN = (c % 125) < 100;
      if (SDRAM_FIFO_RD_EN) check("t2_pop_data", 32'(SDRAM_FIFO_RD_DATA), 32'(exp_pix));
      tick();
      if (SDRAM_FIFO_RD_EN) exp_pix++;
    end
    SDRAM_FIFO_RD_EN = 1'b0;
    check("t2_fifth_addr", log_at(4), 32'h100);
    check("t2_sixth_addr", log_at(5), 32'h110);
    check("t2_underflow", 32'(underflow), 32'd0);
    check("t2_overflow", 32'(overflow), 32'd0);

    // Simultaneous push and pop at 63 words.
    sdram_init_done = 1'b0;
    repeat (40) tick();
    pulse_frame_start();
    check("t3_flush_cnt", 32'(fifo_cnt), 32'd0);
    data_ctr        = '0;
    sdram_init_done = 1'b1;
    n = 0;
    while (fifo_cnt != 7'd64 && n < Budget) begin tick(); n++; end
    check("t3_refill_done", 32'(n < Budget), 32'd1);
    sdram_init_done  = 1'b0;
    SDRAM_FIFO_RD_EN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_pop_data", 32'(SDRAM_FIFO_RD_DATA), 32'(i));
      tick();
    end
    SDRAM_FIFO_RD_EN = 1'b0;
    check("t3_cnt_48", 32'(fifo_cnt), 32'd48);
    sdram_init_done = 1'b1;
    wait_beat("t3_wait_last_beat", 15);
    check("t3_cnt_before", 32'(fifo_cnt), 32'd63);
    check("t3_head_before", 32'(SDRAM_FIFO_RD_DATA), 32'd16);
    SDRAM_FIFO_RD_EN = 1'b1;
    tick();
    SDRAM_FIFO_RD_EN = 1'b0;
    sdram_init_done  = 1'b0;
    check("t3_cnt_after", 32'(fifo_cnt), 32'd63);
    check("t3_head_after", 32'(SDRAM_FIFO_RD_DATA), 32'd17);

    // Drain to empty, then pop while empty.
    SDRAM_FIFO_RD_EN = 1'b1;
    for (int i = 0; i < 63; i++) begin
      if (i == 62) check("t4_last_word", 32'(SDRAM_FIFO_RD_DATA), 32'd79);
      tick();
    end
    check("t4_drained", 32'(fifo_cnt), 32'd0);
    check("t4_no_underflow_yet", 32'(underflow), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t4_empty_data", 32'(SDRAM_FIFO_RD_DATA), 32'd0);
      tick();
    end
    SDRAM_FIFO_RD_EN = 1'b0;
    check("t4_underflow_set", 32'(underflow), 32'd1);
    check("t4_cnt_still_0", 32'(fifo_cnt), 32'd0);
    pulse_frame_start();
    check("t4_underflow_clr", 32'(underflow), 32'd0);

    // frame_start during WAIT after five beats.
    data_ctr        = '0;
    n0              = addr_log.size();
    sdram_init_done = 1'b1;
    wait_beat("t5_wait_beat5", 5);
    check("t5_cnt_5", 32'(fifo_cnt), 32'd5);
    check("t5_head", 32'(SDRAM_FIFO_RD_DATA), 32'd0);
    pulse_frame_start();
    check("t5_cnt_flushed", 32'(fifo_cnt), 32'd0);
    wait_log("t5_wait_next_req", n0 + 2);
    check("t5_first_addr", log_at(n0), 32'h100);
    check("t5_next_addr", log_at(n0 + 1), 32'h100);
    check("t5_discarded", 32'(fifo_cnt), 32'd0);

    // frame_start together with rd_ack in REQ.
    wait_log("t6_wait_req_110", n0 + 3);
    check("t6_req_addr", log_at(n0 + 2), 32'h110);
    check("t6_cnt_16", 32'(fifo_cnt), 32'd16);
    n = 0;
    while (!rd_ack && n < Budget) begin tick(); n++; end
    check("t6_wait_ack", 32'(n < Budget), 32'd1);
    pulse_frame_start();
    check("t6_cnt_flushed", 32'(fifo_cnt), 32'd0);
    wait_log("t6_wait_after_discard", n0 + 4);
    check("t6_restart_addr", log_at(n0 + 3), 32'h100);
    check("t6_discarded", 32'(fifo_cnt), 32'd0);
    wait_log("t6_wait_req_110b", n0 + 5);
    check("t6_req_addr_b", log_at(n0 + 4), 32'h110);
    wait_beat("t6_wait_beat3", 3);
    check("t6_cnt_19", 32'(fifo_cnt), 32'd19);
    check("t6_addr_110", 32'(rd_addr), 32'h110);
    #1 Rst_n = 1'b0;
    #1;
    check("t6_rst_rd_req", 32'(rd_req), 32'd0);
    check("t6_rst_rd_addr", 32'(rd_addr), 32'h100);
    check("t6_rst_cnt", 32'(fifo_cnt), 32'd0);
    check("t6_rst_rd_data", 32'(SDRAM_FIFO_RD_DATA), 32'd0);
    check("t6_rst_flags", 32'({underflow, overflow}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
